csel_adder_pipe: RTL
====================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder.
- Operands are split into NBLK = IWL/BLK blocks. Each block computes both carry-in cases with a ripple-carry sub-adder (carry 0 and carry 1). The carry registered from the previous stage selects between them.
- One pipeline stage per block, with a valid/ready handshake on input and output.
- Sits in the arithmetic datapath as the clocked, wide-operand replacement for the fixed 8-bit combinational carry-select adder.

Parameters:
- IWL, 16, operand width in bits; must be a positive multiple of BLK.
- BLK, 4, carry-select block width in bits; 1..IWL.
- Derived localparam NBLK = IWL/BLK: number of blocks, equal to the number of pipeline stages.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands on a, b, cin are valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  IWL  operand A, unsigned or two's complement.
- b  in  IWL  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  s and cout hold a completed result.
- out_ready  in  1  downstream accepts the result.
- s  out  IWL  sum, (a+b+cin) mod 2^IWL.
- cout  out  1  carry-out of bit IWL-1.
- ovf  out  1  signed overflow; present only with CSA_OVF_EN.

Behaviour:
- Elaboration check: if IWL % BLK != 0 or BLK < 1, elaboration fails via $error in a generate block. No silent truncation.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !stall, where stall = out_valid && !out_ready. in_ready is combinational from out_valid and out_ready.
- Stall: the whole pipeline freezes. All stage registers, valid bits, s and cout hold. No bubble collapsing is required.
- Stage k (k = 0..NBLK-1) contents:
  - valid bit v[k].
  - Registered carry c[k].
  - Partial sum bits [BLK*(k+1)-1:0].
  - Unconsumed operand slices of a and b above bit BLK*(k+1).
- Stage 0 on accept:
  - Block 0 is computed with carry = cin.
  - Stores sum[BLK-1:0], the carry-out, and a/b[IWL-1:BLK].
- Stage k>0:
  - Computes the block-k sum twice, with carry 0 and carry 1.
  - The mux selects by c[k-1]; the selected carry-out becomes c[k].
  - Sum bits are appended and the operand slices shift down.
- Latency: NBLK cycles from input transfer to out_valid, absent stalls. Throughput is one result per cycle when out_ready=1.
- Output mapping: out_valid = v[NBLK-1]; s and cout are the last-stage registers.
- When not stalled, v[k] <= v[k-1] (v[0] <= in_valid). Data registers load only when the source valid is 1; otherwise they hold, to reduce toggling.
- Reset: asynchronous on rst_n low, effective immediately regardless of clk.
  - All v[k] = 0, so out_valid = 0.
  - s = 0, cout = 0, ovf = 0.
  - in_ready = 1 during and after reset, since out_valid = 0.
  - Reset mid-operation discards all in-flight results.
  - Release is synchronised externally; the first accept is on the first rising edge with rst_n=1.
- Wrap-around: the all-ones + 1 sum wraps to 0 with cout=1. No saturation.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Degenerate BLK == IWL: NBLK=1, a single-stage registered ripple adder.

Optional Feature:
- Macro: CSA_OVF_EN.
- Defined:
  - Adds port ovf, registered in the last stage with s and cout.
  - ovf = (a[IWL-1] == b[IWL-1]) && (s[IWL-1] != a[IWL-1]), using the operand MSBs carried through the pipeline.
  - Reset value 0; holds during stall.
- Undefined: port ovf is absent and no MSB tracking registers exist.

Test Plan (IWL=16, BLK=4, latency 4):
- Reset: assert rst_n=0 mid-stream with 3 operations in flight -> out_valid=0, s=0, cout=0 immediately. After release, no stale results emerge and in_ready=1.
- Basic: a=16'h1234, b=16'h4321, cin=0 -> exactly 4 cycles later out_valid=1, s=16'h5555, cout=0.
- Carry chain across all blocks: a=16'hFFFF, b=16'h0000, cin=1 -> s=16'h0000, cout=1. a=16'hFFFF, b=16'hFFFF, cin=1 -> s=16'hFFFF, cout=1.
- Streaming: 8 back-to-back vectors with out_ready=1 -> 8 consecutive results in order, one per cycle, matching the reference model.
- Backpressure: out_ready=0 for 5 cycles while results are pending -> in_ready=0, while s, cout and out_valid hold stable. After release, no result is lost or duplicated and the order is preserved.
- CSA_OVF_EN: a=16'h7FFF, b=16'h0001 -> s=16'h8000, ovf=1, cout=0. a=16'h8000, b=16'hFFFF -> s=16'h7FFF, ovf=1, cout=1. a=16'h0001, b=16'h0001 -> ovf=0.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// -----------------------------------------------------------------------------
// csel_adder_pipe
//
// Pipelined carry-select adder. The IWL-bit operands are cut into
// NBLK = IWL/BLK blocks of BLK bits, and each block gets its own pipeline
// stage. Stage 0 adds block 0 with the external carry-in. Every later stage
// adds its block twice, once with carry 0 and once with carry 1, and uses the
// carry registered by the previous stage to pick one result. Each stage
// appends its sum bits to the partial sum and shifts the unconsumed operand
// slices down, so the next block always sits at bits [BLK-1:0].
//
// Handshake: the input transfers on in_valid && in_ready, and the output
// transfers on out_valid && out_ready. When the last stage holds a result
// that is not accepted, the whole pipeline freezes.
//
// Parameters:
//   IWL  operand width in bits; must be a positive multiple of BLK
//   BLK  carry-select block width in bits, 1..IWL
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b and cin carry valid operands
//   in_ready   out  the block accepts operands this cycle (combinational)
//   a, b       in   IWL-bit operands (unsigned or two's complement)
//   cin        in   carry into bit 0
//   out_valid  out  s/cout hold a completed result
//   out_ready  in   downstream accepts the result
//   s          out  (a + b + cin) mod 2^IWL, registered
//   cout       out  carry out of bit IWL-1, registered
//   ovf        out  signed overflow, registered (only with CSA_OVF_EN)
//
// Optional feature, macro CSA_OVF_EN:
//   When defined, the operand MSBs travel down the pipeline with the data.
//   The last stage then registers the signed-overflow flag alongside s and
//   cout. When undefined, neither the ovf port nor the MSB registers exist.
// -----------------------------------------------------------------------------
module csel_adder_pipe #(
    parameter int IWL = 16,
    parameter int BLK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IWL-1:0] a,
    input  logic [IWL-1:0] b,
    input  logic           cin,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [IWL-1:0] s,
    output logic           cout
`ifdef CSA_OVF_EN
    ,
    output logic           ovf
`endif
);

    // An illegal BLK is clamped here only so the elaboration error below
    // can be reported instead of a divide-by-zero.
    localparam int NBLK = (BLK >= 1) ? (IWL / BLK) : 1;

    // Reject any geometry that would drop operand bits.
    if ((BLK < 1) || (BLK > IWL) || ((IWL % ((BLK >= 1) ? BLK : 1)) != 0)) begin : g_param_check
        $error("csel_adder_pipe: IWL (%0d) must be a positive multiple of BLK (%0d)", IWL, BLK);
    end

    // -------------------------------------------------------------------------
    // BLK-bit ripple-carry adder. The result is {carry_out, sum}.
    // -------------------------------------------------------------------------
    function automatic logic [BLK:0] ripple_add(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           ci
    );
        logic [BLK-1:0] sum_v;
        logic           c_v;
        c_v   = ci;
        sum_v = {BLK{1'b0}};
        for (int i = 0; i < BLK; i++) begin
            sum_v[i] = x[i] ^ y[i] ^ c_v;
            c_v      = (x[i] & y[i]) | (c_v & (x[i] ^ y[i]));
        end
        return {c_v, sum_v};
    endfunction

    // -------------------------------------------------------------------------
    // Stage state. Entry k belongs to pipeline stage k.
    //   r_v    : stage holds a live operation
    //   r_c    : carry out of block k
    //   r_sum  : sum bits [BLK*(k+1)-1:0]; the bits above are zero
    //   r_a/b  : operand bits not yet consumed, shifted down to bit 0
    // -------------------------------------------------------------------------
    logic           r_v   [NBLK];
    logic           r_c   [NBLK];
    logic [IWL-1:0] r_sum [NBLK];
    logic [IWL-1:0] r_a   [NBLK];
    logic [IWL-1:0] r_b   [NBLK];

`ifdef CSA_OVF_EN
    // Operand sign bits, carried along because the operand slices are
    // consumed long before the last stage.
    logic           r_amsb [NBLK];
    logic           r_bmsb [NBLK];
    logic           r_ovf;
`endif

    logic w_stall;

    // A finished result that is not accepted freezes every stage.
    assign w_stall   = r_v[NBLK-1] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_v[NBLK-1];
    assign s         = r_sum[NBLK-1];
    assign cout      = r_c[NBLK-1];
`ifdef CSA_OVF_EN
    assign ovf       = r_ovf;
`endif

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic           w_src_v;
        logic [IWL-1:0] w_src_sum;
        logic [IWL-1:0] w_src_a;
        logic [IWL-1:0] w_src_b;
        logic [BLK:0]   w_blk;
        logic [IWL-1:0] w_sum_nxt;

        if (k == 0) begin : g_src_in
            // Stage 0 reads straight from the input port.
            assign w_src_v   = in_valid;
            assign w_src_sum = {IWL{1'b0}};
            assign w_src_a   = a;
            assign w_src_b   = b;
            // Block 0 knows its carry up front, so one adder is enough.
            assign w_blk     = ripple_add(w_src_a[BLK-1:0], w_src_b[BLK-1:0], cin);
        end else begin : g_src_prev
            logic [BLK:0] w_blk0;
            logic [BLK:0] w_blk1;

            assign w_src_v   = r_v[k-1];
            assign w_src_sum = r_sum[k-1];
            assign w_src_a   = r_a[k-1];
            assign w_src_b   = r_b[k-1];

            // Both carry hypotheses are computed in parallel.
            assign w_blk0    = ripple_add(w_src_a[BLK-1:0], w_src_b[BLK-1:0], 1'b0);
            assign w_blk1    = ripple_add(w_src_a[BLK-1:0], w_src_b[BLK-1:0], 1'b1);

            // The carry registered by the previous stage picks the hypothesis.
            always_comb begin
                if (r_c[k-1]) begin
                    w_blk = w_blk1;
                end else begin
                    w_blk = w_blk0;
                end
            end
        end

        // Append this block's sum bits above the partial sum received.
        always_comb begin
            w_sum_nxt                = w_src_sum;
            w_sum_nxt[BLK*k +: BLK]  = w_blk[BLK-1:0];
        end

        // Stage registers: valid advances every unstalled cycle, and data
        // loads only behind a valid source to avoid needless toggling.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v[k]   <= 1'b0;
                r_c[k]   <= 1'b0;
                r_sum[k] <= {IWL{1'b0}};
                r_a[k]   <= {IWL{1'b0}};
                r_b[k]   <= {IWL{1'b0}};
            end else if (!w_stall) begin
                r_v[k] <= w_src_v;
                if (w_src_v) begin
                    r_c[k]   <= w_blk[BLK];
                    r_sum[k] <= w_sum_nxt;
                    r_a[k]   <= w_src_a >> BLK;
                    r_b[k]   <= w_src_b >> BLK;
                end
            end
        end

`ifdef CSA_OVF_EN
        logic w_src_amsb;
        logic w_src_bmsb;

        if (k == 0) begin : g_msb_in
            assign w_src_amsb = a[IWL-1];
            assign w_src_bmsb = b[IWL-1];
        end else begin : g_msb_prev
            assign w_src_amsb = r_amsb[k-1];
            assign w_src_bmsb = r_bmsb[k-1];
        end

        // Sign bits ride along with the data registers of this stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_amsb[k] <= 1'b0;
                r_bmsb[k] <= 1'b0;
            end else if (!w_stall && w_src_v) begin
                r_amsb[k] <= w_src_amsb;
                r_bmsb[k] <= w_src_bmsb;
            end
        end

        if (k == NBLK - 1) begin : g_ovf
            // Overflow: operands agree in sign but the sum's sign differs.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (!w_stall && w_src_v) begin
                    r_ovf <= (w_src_amsb == w_src_bmsb) &&
                             (w_sum_nxt[IWL-1] != w_src_amsb);
                end
            end
        end
`endif
    end

endmodule
